// File: rtl/ex_muldiv_if.sv
// Pipeline-side bundle for the EX-stage HI/LO multiply/divide unit.
// master = ID/EX pipeline driving the instruction, slave = ex_muldiv.
interface ex_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic             flush;
  logic [5:0]       funct_in;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic             stall;
  logic [WIDTH-1:0] hilo_rd;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output op_valid, flush, funct_in, rs_val, rt_val,
    input  busy, stall, hilo_rd, hi_out, lo_out
  );

  modport slave (
    input  op_valid, flush, funct_in, rs_val, rt_val,
    output busy, stall, hilo_rd, hi_out, lo_out
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative HI/LO multiply/divide unit for the EX stage.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division, both on operand
// magnitudes with a sign fix-up in the final cycle. Owns HI/LO and serves
// MTHI/MTLO/MFHI/MFLO; requests a pipeline stall for HI/LO instructions that
// arrive while an operation is in flight.
module ex_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  ex_muldiv_if.slave bus
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  // acc_hi/acc_lo: partial product (mul) or remainder/quotient-dividend (div)
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q;
  logic [WIDTH-1:0] acc_hi_d, acc_lo_d;
  logic [WIDTH-1:0] opnd_q;      // multiplicand (mul) or divisor (div) magnitude
  logic             mul_q;
  logic             neg_q;       // product/quotient must be negated
  logic             rneg_q;      // remainder must be negated
  logic             dz_q;        // divide by zero
  logic [WIDTH-1:0] rs_orig_q;

  logic             is_mul, is_div, is_signed, hilo_op;
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic             busy;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // Decode the EX instruction and form operand magnitudes
  always_comb begin
    is_mul    = (bus.funct_in == F_MULT) || (bus.funct_in == F_MULTU);
    is_div    = (bus.funct_in == F_DIV)  || (bus.funct_in == F_DIVU);
    is_signed = (bus.funct_in == F_MULT) || (bus.funct_in == F_DIV);
    hilo_op   = bus.op_valid &&
                (is_mul || is_div ||
                 (bus.funct_in == F_MFHI) || (bus.funct_in == F_MTHI) ||
                 (bus.funct_in == F_MFLO) || (bus.funct_in == F_MTLO));
    rs_neg    = is_signed && bus.rs_val[WIDTH-1];
    rt_neg    = is_signed && bus.rt_val[WIDTH-1];
    rs_mag    = rs_neg ? ('0 - bus.rs_val) : bus.rs_val;
    rt_mag    = rt_neg ? ('0 - bus.rt_val) : bus.rt_val;
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide
  always_comb begin
    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;
    sum      = '0;
    rem_sh   = '0;
    diff     = '0;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    if (mul_q) begin
      sum      = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
      acc_hi_d = sum[WIDTH:1];
      acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
    end else begin
      rem_sh = {acc_hi_q, acc_lo_q[WIDTH-1]};
      diff   = rem_sh - {1'b0, opnd_q};
      // diff[WIDTH] clear means the shifted remainder covered the divisor
      acc_hi_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      acc_lo_d = {acc_lo_q[WIDTH-2:0], ~diff[WIDTH]};
    end
  end

  // Sign fix-up of the magnitude results
  always_comb begin
    prod_fix = neg_q  ? ('0 - {acc_hi_q, acc_lo_q}) : {acc_hi_q, acc_lo_q};
    quot_fix = neg_q  ? ('0 - acc_lo_q) : acc_lo_q;
    rem_fix  = rneg_q ? ('0 - acc_hi_q) : acc_hi_q;
  end

  // Control FSM with HI/LO and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      mul_q     <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
      rs_orig_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hilo_op && !bus.flush) begin
            if (is_mul || is_div) begin
              mul_q     <= is_mul;
              acc_hi_q  <= '0;
              acc_lo_q  <= is_mul ? rt_mag : rs_mag;
              opnd_q    <= is_mul ? rs_mag : rt_mag;
              neg_q     <= rs_neg ^ rt_neg;
              rneg_q    <= rs_neg;
              dz_q      <= is_div && (bus.rt_val == '0);
              rs_orig_q <= bus.rs_val;
              cnt_q     <= '0;
              state_q   <= S_ITER;
            end else if (bus.funct_in == F_MTHI) begin
              hi_q <= bus.rs_val;
            end else if (bus.funct_in == F_MTLO) begin
              lo_q <= bus.rs_val;
            end
          end
        end
        S_ITER: begin
          if (bus.flush) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              cnt_q   <= '0;
              state_q <= S_FIN;
            end
          end
        end
        S_FIN: begin
          if (!bus.flush) begin
            if (mul_q) begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end else if (dz_q) begin
              hi_q <= rs_orig_q;
              lo_q <= '1;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Status, stall request and MFHI/MFLO read port
  always_comb begin
    busy        = (state_q != S_IDLE);
    bus.busy    = busy;
    bus.stall   = busy && hilo_op;
    bus.hi_out  = hi_q;
    bus.lo_out  = lo_q;
    bus.hilo_rd = '0;
    if (!busy && bus.op_valid) begin
      if (bus.funct_in == F_MFHI)      bus.hilo_rd = hi_q;
      else if (bus.funct_in == F_MFLO) bus.hilo_rd = lo_q;
    end
  end

endmodule
